// File: rtl/draw_pkg.sv
// Shared types and constants for the object-drawer command sequencer.
// Holds the FSM state enum, item codes, position limits and size defaults.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_E,
        ERASE,
        SYNC_D,
        DRAW,
        DONE
    } state_t;

    localparam logic ITEM_PRESS = 1'b1;
    localparam logic ITEM_GARB  = 1'b0;

    localparam logic [2:0] MAX_PRESS_POS = 3'd5;
    localparam logic [2:0] MAX_GARB_POS  = 3'd3;

    localparam int DEF_PRESS_W = 40;
    localparam int DEF_PRESS_H = 60;
    localparam int DEF_GARB_W  = 20;
    localparam int DEF_GARB_H  = 20;
    localparam int DEF_CNT_W   = 12;

    typedef struct packed {
        logic       item;
        logic [2:0] old_pos;
        logic [2:0] new_pos;
        logic       skip_erase;
    } draw_cmd_t;

    // Old position only matters when an erase pass will actually run.
    function automatic logic cmd_ok(input draw_cmd_t c);
        logic [2:0] lim;
        lim = (c.item == ITEM_PRESS) ? MAX_PRESS_POS : MAX_GARB_POS;
        return (c.new_pos <= lim) && (c.skip_erase || (c.old_pos <= lim));
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Two-entry command FIFO placed in front of the draw sequencer.
// Ports: clk, reset_n (sync, active-low), push_i/data_i, pop_i/data_o,
// empty_o, count_o (0..2). The caller never pushes while full.
import draw_pkg::*;

module draw_cmd_fifo (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  draw_cmd_t  data_i,
    input  logic       pop_i,
    output draw_cmd_t  data_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    draw_cmd_t  mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/draw_sequencer.sv
// Command-side controller for the object drawer: erase pass, then draw pass,
// each exactly W*H cycles, preceded by a one-cycle drawer counter sync.
// Ports: clk, reset_n (sync, active-low); cmd_valid/cmd_ready handshake with
// cmd_item, cmd_old_pos, cmd_new_pos, cmd_skip_erase; drawer side item, erase,
// position, draw_rst_n, plot_en; status busy, done, err (err pulses with done).
// Build option DRAW_SEQ_QUEUE_EN adds a 2-entry command FIFO (draw_cmd_fifo).
import draw_pkg::*;

module draw_sequencer #(
    parameter int PRESS_W = DEF_PRESS_W,
    parameter int PRESS_H = DEF_PRESS_H,
    parameter int GARB_W  = DEF_GARB_W,
    parameter int GARB_H  = DEF_GARB_H,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_item,
    input  logic [2:0] cmd_old_pos,
    input  logic [2:0] cmd_new_pos,
    input  logic       cmd_skip_erase,
    output logic       item,
    output logic       erase,
    output logic [2:0] position,
    output logic       draw_rst_n,
    output logic       plot_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] LAST_PRESS = CNT_W'(PRESS_W * PRESS_H - 1);
    localparam logic [CNT_W-1:0] LAST_GARB  = CNT_W'(GARB_W * GARB_H - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       new_pos_q;
    logic             item_q;
    logic             erase_q;
    logic [2:0]       pos_q;
    logic             rst_q;
    logic             plot_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    draw_cmd_t        in_cmd;
    draw_cmd_t        sel_cmd;
    logic             fire;
    logic             launch;
    logic             idle_or_done;
    logic             sel_ok;
    logic             ready_d;
    logic [CNT_W-1:0] pass_last;
    logic             at_end;

    assign in_cmd = '{
        item:       cmd_item,
        old_pos:    cmd_old_pos,
        new_pos:    cmd_new_pos,
        skip_erase: cmd_skip_erase
    };

    assign fire         = cmd_valid && ready_q;
    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

`ifdef DRAW_SEQ_QUEUE_EN
    draw_cmd_t  q_head;
    logic       q_empty;
    logic       q_push;
    logic       q_pop;
    logic [1:0] q_cnt;
    logic [1:0] q_cnt_d;

    // An empty queue lets a command arriving in IDLE/DONE start directly,
    // keeping the unqueued accept-to-SYNC latency of one cycle.
    assign q_pop   = idle_or_done && !q_empty;
    assign q_push  = fire && !(idle_or_done && q_empty);
    assign launch  = idle_or_done && (!q_empty || fire);
    assign sel_cmd = q_empty ? in_cmd : q_head;
    assign q_cnt_d = q_cnt + {1'b0, q_push} - {1'b0, q_pop};
    assign ready_d = (q_cnt_d != 2'd2);

    draw_cmd_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (q_push),
        .data_i  (in_cmd),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .empty_o (q_empty),
        .count_o (q_cnt)
    );
`else
    assign launch  = (state_q == IDLE) && fire;
    assign sel_cmd = in_cmd;
    // Ready is raised for the cycle the FSM sits in IDLE.
    assign ready_d = idle_or_done && !launch;
`endif

    assign sel_ok    = cmd_ok(sel_cmd);
    assign pass_last = item_q ? LAST_PRESS : LAST_GARB;
    assign at_end    = (cnt_q == pass_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            new_pos_q <= 3'd0;
            item_q    <= 1'b0;
            erase_q   <= 1'b0;
            pos_q     <= 3'd0;
            rst_q     <= 1'b0;
            plot_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= ready_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (launch) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        plot_q <= 1'b0;
                        if (!sel_ok) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            item_q    <= sel_cmd.item;
                            new_pos_q <= sel_cmd.new_pos;
                            rst_q     <= 1'b0;
                            if (sel_cmd.skip_erase) begin
                                state_q <= SYNC_D;
                                erase_q <= 1'b0;
                                pos_q   <= sel_cmd.new_pos;
                            end else begin
                                state_q <= SYNC_E;
                                erase_q <= 1'b1;
                                pos_q   <= sel_cmd.old_pos;
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SYNC_E: begin
                    state_q <= ERASE;
                    rst_q   <= 1'b1;
                    plot_q  <= 1'b1;
                end
                ERASE: begin
                    if (at_end) begin
                        state_q <= SYNC_D;
                        cnt_q   <= '0;
                        rst_q   <= 1'b0;
                        plot_q  <= 1'b0;
                        erase_q <= 1'b0;
                        pos_q   <= new_pos_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SYNC_D: begin
                    state_q <= DRAW;
                    rst_q   <= 1'b1;
                    plot_q  <= 1'b1;
                end
                DRAW: begin
                    if (at_end) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign item       = item_q;
    assign erase      = erase_q;
    assign position   = pos_q;
    assign draw_rst_n = rst_q;
    assign plot_en    = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
